// File: rtl/prime_bus_master_if.sv
`default_nettype none
// prime_bus_master_if: command/result handshake and peripheral bus for prime_bus_master (rev 1.0)
interface prime_bus_master_if;
  logic        cmd_valid;
  logic [31:0] cmd_n;
  logic        cmd_ready;
  logic        res_valid;
  logic [31:0] res_prime;
  logic        res_error;
  logic        busy;
  logic [15:0] saddress;
  logic        swr;
  logic        srd;
  logic [31:0] sdata_wr;
  logic [31:0] sdata_rd;

  modport master (
    input  cmd_valid, cmd_n, sdata_rd,
    output cmd_ready, res_valid, res_prime, res_error, busy,
           saddress, swr, srd, sdata_wr
  );

  modport slave (
    output cmd_valid, cmd_n, sdata_rd,
    input  cmd_ready, res_valid, res_prime, res_error, busy,
           saddress, swr, srd, sdata_wr
  );
endinterface
`default_nettype wire

// File: rtl/prime_bus_master.sv
`default_nettype none
// prime_bus_master: writes N to a prime peripheral, polls its status, reads back the N-th prime (rev 1.0)
module prime_bus_master #(
  parameter int STROBE_CYCLES = 2,
  parameter int POLL_GAP      = 4,
  parameter int MAX_POLLS     = 1000
) (
  input  wire                        clk,
  input  wire                        n_reset,
  prime_bus_master_if.master         bus
);

  localparam logic [15:0] ADDR_ARG    = 16'h0224;
  localparam logic [15:0] ADDR_RESULT = 16'h0234;
  localparam logic [15:0] ADDR_STATUS = 16'h023C;
  localparam logic [31:0] STATUS_DONE = 32'd2;
  localparam logic [7:0]  STB_LAST    = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST    = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;
  localparam logic [15:0] POLL_LIMIT  = 16'(MAX_POLLS);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_SETUP, S_WR_STB, S_WR_HOLD, S_GAP,
    S_ST_SETUP, S_ST_STB, S_ST_HOLD,
    S_RS_SETUP, S_RS_STB, S_RS_HOLD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] n_q, n_d;
  logic [15:0] poll_q, poll_d;
  logic [31:0] rdata_q, rdata_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_prime_q, res_prime_d;
  logic        res_error_q, res_error_d;
  logic        busy_q, busy_d;
  logic [15:0] saddress_q, saddress_d;
  logic        swr_q, swr_d;
  logic        srd_q, srd_d;
  logic [31:0] sdata_wr_q, sdata_wr_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    poll_d      = poll_q;
    rdata_d     = rdata_q;
    res_prime_d = res_prime_q;
    res_error_d = res_error_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          n_d         = bus.cmd_n;
          poll_d      = 16'd0;
          res_prime_d = 32'd0;
          res_error_d = (bus.cmd_n == 32'd0);
          state_d     = (bus.cmd_n == 32'd0) ? S_DONE : S_WR_SETUP;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_STB;
        cnt_d   = STB_LAST;
      end
      S_WR_STB: begin
        if (cnt_q == 8'd0) state_d = S_WR_HOLD;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_WR_HOLD: begin
        state_d = (POLL_GAP > 0) ? S_GAP : S_ST_SETUP;
        cnt_d   = GAP_LAST;
      end
      S_GAP: begin
        if (cnt_q == 8'd0) state_d = S_ST_SETUP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_ST_SETUP: begin
        state_d = S_ST_STB;
        cnt_d   = STB_LAST;
      end
      S_ST_STB: begin
        if (cnt_q == 8'd0) begin
          state_d = S_ST_HOLD;
          rdata_d = bus.sdata_rd;
          if (poll_q != 16'hFFFF) poll_d = poll_q + 16'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ST_HOLD: begin
        // A done status wins even on the final permitted poll.
        if (rdata_q == STATUS_DONE) begin
          state_d = S_RS_SETUP;
        end else if (poll_q == POLL_LIMIT) begin
          state_d     = S_DONE;
          res_error_d = 1'b1;
          res_prime_d = 32'd0;
        end else begin
          state_d = (POLL_GAP > 0) ? S_GAP : S_ST_SETUP;
          cnt_d   = GAP_LAST;
        end
      end
      S_RS_SETUP: begin
        state_d = S_RS_STB;
        cnt_d   = STB_LAST;
      end
      S_RS_STB: begin
        if (cnt_q == 8'd0) begin
          state_d = S_RS_HOLD;
          rdata_d = bus.sdata_rd;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RS_HOLD: begin
        state_d     = S_DONE;
        res_error_d = 1'b0;
        res_prime_d = rdata_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered images of the state being entered.
    saddress_d  = 16'd0;
    sdata_wr_d  = 32'd0;
    swr_d       = 1'b0;
    srd_d       = 1'b0;
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
    res_valid_d = (state_d == S_DONE);
    case (state_d)
      S_WR_SETUP, S_WR_HOLD: begin
        saddress_d = ADDR_ARG;
        sdata_wr_d = n_d;
      end
      S_WR_STB: begin
        saddress_d = ADDR_ARG;
        sdata_wr_d = n_d;
        swr_d      = 1'b1;
      end
      S_ST_SETUP, S_ST_HOLD: saddress_d = ADDR_STATUS;
      S_ST_STB: begin
        saddress_d = ADDR_STATUS;
        srd_d      = 1'b1;
      end
      S_RS_SETUP, S_RS_HOLD: saddress_d = ADDR_RESULT;
      S_RS_STB: begin
        saddress_d = ADDR_RESULT;
        srd_d      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      n_q         <= 32'd0;
      poll_q      <= 16'd0;
      rdata_q     <= 32'd0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_prime_q <= 32'd0;
      res_error_q <= 1'b0;
      busy_q      <= 1'b0;
      saddress_q  <= 16'd0;
      swr_q       <= 1'b0;
      srd_q       <= 1'b0;
      sdata_wr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      poll_q      <= poll_d;
      rdata_q     <= rdata_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_prime_q <= res_prime_d;
      res_error_q <= res_error_d;
      busy_q      <= busy_d;
      saddress_q  <= saddress_d;
      swr_q       <= swr_d;
      srd_q       <= srd_d;
      sdata_wr_q  <= sdata_wr_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_prime = res_prime_q;
  assign bus.res_error = res_error_q;
  assign bus.busy      = busy_q;
  assign bus.saddress  = saddress_q;
  assign bus.swr       = swr_q;
  assign bus.srd       = srd_q;
  assign bus.sdata_wr  = sdata_wr_q;

endmodule
`default_nettype wire
